medidor_frec: RTL and testbench
===============================

# medidor_frec

Frequency and period meter for a slow digital signal, timed by the board clock. It is the receiving end of the team's clock-divider outputs: it measures a divided clock, or any external square wave, against the 50 MHz input clock. It reports the rising-edge count per gate window and the clock-cycle period between consecutive rising edges. It is used to verify divider settings on hardware and to drive frequency readouts on the display.

## Interface
- `FREC_IN`, 50000000: input clock frequency in Hz; documentation only, not used in logic.
- `GATE_CYCLES`, 50000000: gate window length in `clk_intput` cycles (1 s at 50 MHz); legal range ≥ 2.
- `CNT_W`, 27: width of all counters and result registers; must hold `GATE_CYCLES`.

Ports:
- `clk_intput`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sig_in`  in  1  measured signal, asynchronous to `clk_intput`.
- `enable`  in  1  measurement enable, synchronous.
- `freq_out`  out  CNT_W  rising edges counted in the last completed gate window.
- `freq_valid`  out  1  one-cycle pulse when `freq_out` updates.
- `period_out`  out  CNT_W  `clk_intput` cycles between the last two rising edges.
- `period_valid`  out  1  one-cycle pulse when `period_out` updates.
- `ovf`  out  1  sticky: a counter saturated since the last enable rise.

## Operation
- **Input conditioning:** `sig_in` → 2-flop synchronizer `s1`, `s2` → delay flop `s3`. `rise = s2 & ~s3`. No glitch filtering.
- **States:**
  - `IDLE`: `enable` = 0. Gate timer, edge counter and period counter are held at 0. Result outputs hold their last values and valid pulses are 0.
  - `ARMED`: gate window running. The period counter is not yet meaningful; the block is waiting for the first `rise`.
  - `RUN`: gate window and period measurement are both running.
- **Transitions:**
  - `IDLE` → `ARMED` when `enable` = 1. `ovf` clears in the same cycle.
  - `ARMED` → `RUN` on the first `rise`. `period_cnt` is loaded with 1 and there is no `period_valid`.
  - `ARMED` or `RUN` → `IDLE` whenever `enable` = 0. This takes priority over every other event. Any partial window is discarded with no pulse.
- **Gate timer:**
  - Counts 0..`GATE_CYCLES`-1 in `ARMED` and `RUN`.
  - At terminal count: `freq_out` ← `edge_cnt` + `rise`, `freq_valid` = 1 next cycle, `edge_cnt` ← 0, timer ← 0.
  - A `rise` in the terminal cycle counts toward the closing window, never toward the next one.
- **Edge counter:**
  - Increments on `rise`.
  - Saturates at 2^CNT_W−1 and sets `ovf`.
- **Period counter** (`RUN` only):
  - Increments every cycle.
  - On `rise`: `period_out` ← `period_cnt`, `period_valid` pulses, `period_cnt` ← 1.
  - Saturates at 2^CNT_W−1 and sets `ovf`. If saturated when `rise` arrives, `period_out` reports all-ones, which means timeout.
- **Simultaneous gate terminal and `rise`:** both `freq_valid` and `period_valid` pulse in the same cycle.
- **Width rule:** all counters are unsigned `CNT_W` bits. Arithmetic never wraps; it saturates.

## Timing
- **Reset values** (`rst_n` low, asynchronous):
  - `freq_out` = 0, `period_out` = 0, `freq_valid` = 0, `period_valid` = 0, `ovf` = 0.
  - State = `IDLE`; synchronizer flops = 0.
- **Reset mid-window:** the partial measurement is lost. After release, the block needs `enable` high to begin.
- **Latency from `sig_in`:** a `sig_in` rising edge produces `rise` 3 `clk_intput` edges later (2 synchronizer flops + the `s3` compare).
- **Result timing:** `period_valid` and the `period_out` update appear 1 cycle after `rise`. `freq_valid` appears 1 cycle after the gate terminal count.
- **Window timing:** the first window closes `GATE_CYCLES` cycles after the first `enable`-high cycle. Later windows are back-to-back with no dead cycle.
- **Input limits:** `sig_in` high and low times must each be ≥ 2 `clk_intput` cycles. Faster input undercounts; this is not detected.
- **Valid pulses:** exactly 1 cycle wide, never asserted in `IDLE`.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-run with `GATE_CYCLES` = 100 → all outputs 0 immediately, no valid pulse until `enable` has been high ≥ 100 cycles after release.
- **Basic measurement:** `GATE_CYCLES` = 100, `sig_in` period 10 cycles (5 high / 5 low), `enable` = 1 → every 100 cycles `freq_valid` pulses with `freq_out` = 10 (±1 on the first window). `period_valid` pulses every 10 cycles with `period_out` = 10.
- **Divider loopback:** feed a divide-by-(2·(N+1)) clock with N = 24, i.e. a 50-cycle period, `GATE_CYCLES` = 1000 → `period_out` = 50, `freq_out` = 20.
- **Edge on terminal cycle:** align a `rise` with gate terminal count → that edge is counted in the closing window. `freq_valid` and `period_valid` pulse in the same cycle, and the next window starts at 0.
- **Disable / re-enable:** drop `enable` for 3 cycles mid-window → no `freq_valid` for the aborted window, outputs hold their prior values. After re-enable, the first `rise` gives no `period_valid`; the second `rise` gives the correct period.
- **Overflow:** `CNT_W` = 4, `sig_in` held low 40 cycles then one edge → `period_out` = 15, `ovf` = 1. `ovf` stays set until an `enable` 0→1 transition.

Source files
------------

// File: rtl/medidor_frec.sv
// medidor_frec: measures a slow, asynchronous signal against clk_intput.
// Reports rising edges per gate window and the cycle count between consecutive rising edges.
module medidor_frec #(
  parameter int unsigned FREC_IN     = 32'd50000000,
  parameter int unsigned GATE_CYCLES = 32'd50000000,
  parameter int unsigned CNT_W       = 32'd27
) (
  input  logic             clk_intput,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 32'd1);

  if ((GATE_CYCLES < 32'd2) || (FREC_IN == 32'd0)) begin : g_bad_gate
    $error("medidor_frec: GATE_CYCLES must be >= 2 and FREC_IN non-zero");
  end
  if ((64'(GATE_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_width
    $error("medidor_frec: CNT_W too narrow to hold GATE_CYCLES");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t           state_r;
  logic             s1_r;
  logic             s2_r;
  logic             s3_r;
  logic             rise_s;
  logic [CNT_W-1:0] gate_cnt_r;
  logic [CNT_W-1:0] edge_cnt_r;
  logic [CNT_W-1:0] period_cnt_r;
  logic [CNT_W-1:0] freq_out_r;
  logic             freq_valid_r;
  logic [CNT_W-1:0] period_out_r;
  logic             period_valid_r;
  logic             ovf_r;
  logic             gate_last_s;
  logic [CNT_W-1:0] edge_next_s;
  logic             edge_sat_s;
  logic [CNT_W-1:0] period_next_s;
  logic             period_sat_s;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic inc);
    logic [CNT_W-1:0] result;
    if (inc && (value != CNT_MAX)) begin
      result = value + CNT_ONE;
    end else begin
      result = value;
    end
    return result;
  endfunction

  // True when an increment is requested but blocked by saturation.
  function automatic logic sat_hit(input logic [CNT_W-1:0] value, input logic inc);
    return inc && (value == CNT_MAX);
  endfunction

  // Two-flop synchronizer plus delay flop for rising-edge detection.
  always_ff @(posedge clk_intput or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= sig_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Next-value arithmetic shared by the window and period logic.
  always_comb begin
    rise_s        = s2_r & ~s3_r;
    gate_last_s   = (gate_cnt_r == GATE_LAST);
    edge_next_s   = sat_inc(edge_cnt_r, rise_s);
    edge_sat_s    = sat_hit(edge_cnt_r, rise_s);
    period_next_s = sat_inc(period_cnt_r, 1'b1);
    period_sat_s  = sat_hit(period_cnt_r, 1'b1);
  end

  // Measurement FSM, counters and registered results.
  always_ff @(posedge clk_intput or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      gate_cnt_r     <= CNT_ZERO;
      edge_cnt_r     <= CNT_ZERO;
      period_cnt_r   <= CNT_ZERO;
      freq_out_r     <= CNT_ZERO;
      freq_valid_r   <= 1'b0;
      period_out_r   <= CNT_ZERO;
      period_valid_r <= 1'b0;
      ovf_r          <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          gate_cnt_r     <= CNT_ZERO;
          edge_cnt_r     <= CNT_ZERO;
          period_cnt_r   <= CNT_ZERO;
          freq_valid_r   <= 1'b0;
          period_valid_r <= 1'b0;
          if (enable) begin
            state_r <= ST_ARMED;
            ovf_r   <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ARMED, ST_RUN: begin
          if (!enable) begin
            // Abandon the partial window; results keep their last values.
            state_r        <= ST_IDLE;
            gate_cnt_r     <= CNT_ZERO;
            edge_cnt_r     <= CNT_ZERO;
            period_cnt_r   <= CNT_ZERO;
            freq_valid_r   <= 1'b0;
            period_valid_r <= 1'b0;
          end else begin
            // A rise in the terminal cycle belongs to the window being closed.
            if (gate_last_s) begin
              gate_cnt_r   <= CNT_ZERO;
              edge_cnt_r   <= CNT_ZERO;
              freq_out_r   <= edge_next_s;
              freq_valid_r <= 1'b1;
            end else begin
              gate_cnt_r   <= gate_cnt_r + CNT_ONE;
              edge_cnt_r   <= edge_next_s;
              freq_valid_r <= 1'b0;
            end

            if (state_r == ST_ARMED) begin
              period_valid_r <= 1'b0;
              if (rise_s) begin
                state_r      <= ST_RUN;
                period_cnt_r <= CNT_ONE;
              end else begin
                state_r      <= ST_ARMED;
                period_cnt_r <= CNT_ZERO;
              end
              ovf_r <= ovf_r | edge_sat_s;
            end else begin
              state_r <= ST_RUN;
              if (rise_s) begin
                period_out_r   <= period_cnt_r;
                period_valid_r <= 1'b1;
                period_cnt_r   <= CNT_ONE;
                ovf_r          <= ovf_r | edge_sat_s;
              end else begin
                period_valid_r <= 1'b0;
                period_cnt_r   <= period_next_s;
                ovf_r          <= ovf_r | edge_sat_s | period_sat_s;
              end
            end
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          gate_cnt_r     <= CNT_ZERO;
          edge_cnt_r     <= CNT_ZERO;
          period_cnt_r   <= CNT_ZERO;
          freq_valid_r   <= 1'b0;
          period_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign freq_out     = freq_out_r;
  assign freq_valid   = freq_valid_r;
  assign period_out   = period_out_r;
  assign period_valid = period_valid_r;
  assign ovf          = ovf_r;

endmodule

// File: tb/tb_medidor_frec.sv
// tb_medidor_frec: three medidor_frec instances on shared stimulus, checked every cycle
// against a time-based reference model, plus table vectors and corner-case sequences.
module tb_medidor_frec;

  localparam int G_A = 100;
  localparam int W_A = 8;
  localparam int G_B = 1000;
  localparam int W_B = 12;
  localparam int G_C = 15;
  localparam int W_C = 4;

  logic           clk_intput = 1'b0;
  logic           rst_n;
  logic           sig_in;
  logic           enable;
  logic [W_A-1:0] fo_a, po_a;
  logic [W_B-1:0] fo_b, po_b;
  logic [W_C-1:0] fo_c, po_c;
  logic           fv_a, pv_a, ov_a, fv_b, pv_b, ov_b, fv_c, pv_c, ov_c;

  medidor_frec #(.GATE_CYCLES(G_A), .CNT_W(W_A)) dut_a (
    .clk_intput(clk_intput), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
    .freq_out(fo_a), .freq_valid(fv_a), .period_out(po_a), .period_valid(pv_a), .ovf(ov_a));
  medidor_frec #(.GATE_CYCLES(G_B), .CNT_W(W_B)) dut_b (
    .clk_intput(clk_intput), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
    .freq_out(fo_b), .freq_valid(fv_b), .period_out(po_b), .period_valid(pv_b), .ovf(ov_b));
  medidor_frec #(.GATE_CYCLES(G_C), .CNT_W(W_C)) dut_c (
    .clk_intput(clk_intput), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
    .freq_out(fo_c), .freq_valid(fv_c), .period_out(po_c), .period_valid(pv_c), .ovf(ov_c));

  always #5 clk_intput = ~clk_intput;

  typedef struct {
    bit active;
    bit have_last;
    int last;
    int win_start;
    int wrises;
    int exp_f;
    int exp_p;
    bit fv;
    bit pv;
    bit ovf;
  } model_t;

  typedef struct {
    bit en;
    int half;
    int cycles;
    int dut;
    int exp_f;
    int exp_p;
  } vec_t;

  model_t m[3];
  int     gcy[3] = '{G_A, G_B, G_C};
  int     mx[3]  = '{255, 4095, 15};
  bit     h1, h2, h3;
  int     cyc = 0;
  int     sig_cnt = 0;
  int     vectors = 0;
  int     miscompares = 0;

  function automatic int out_f(int i);
    case (i)
      0: return int'(fo_a);
      1: return int'(fo_b);
      default: return int'(fo_c);
    endcase
  endfunction

  function automatic int out_p(int i);
    case (i)
      0: return int'(po_a);
      1: return int'(po_b);
      default: return int'(po_c);
    endcase
  endfunction

  function automatic int out_bits(int i);
    case (i)
      0: return {29'd0, fv_a, pv_a, ov_a};
      1: return {29'd0, fv_b, pv_b, ov_b};
      default: return {29'd0, fv_c, pv_c, ov_c};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m[i] = '{default: 0};
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
  endtask

  // Reference: windows located by absolute cycle number, periods as time differences.
  task automatic model_step(input int i, input bit e, input bit r, input int k);
    if (!m[i].active) begin
      m[i].fv = 1'b0;
      m[i].pv = 1'b0;
      if (e) begin
        m[i].active    = 1'b1;
        m[i].ovf       = 1'b0;
        m[i].have_last = 1'b0;
        m[i].win_start = k + 1;
        m[i].wrises    = 0;
      end
    end else if (!e) begin
      m[i].active = 1'b0;
      m[i].fv     = 1'b0;
      m[i].pv     = 1'b0;
    end else begin
      m[i].fv = 1'b0;
      m[i].pv = 1'b0;
      m[i].wrises += int'(r);
      if (m[i].wrises > mx[i]) m[i].ovf = 1'b1;
      if ((k - m[i].win_start) % gcy[i] == gcy[i] - 1) begin
        m[i].exp_f  = (m[i].wrises > mx[i]) ? mx[i] : m[i].wrises;
        m[i].fv     = 1'b1;
        m[i].wrises = 0;
      end
      if (r) begin
        if (m[i].have_last) begin
          m[i].exp_p = (k - m[i].last > mx[i]) ? mx[i] : k - m[i].last;
          m[i].pv    = 1'b1;
        end
        m[i].have_last = 1'b1;
        m[i].last      = k;
      end else if (m[i].have_last && (k - m[i].last >= mx[i])) begin
        m[i].ovf = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int want_bits;
      want_bits = {29'd0, m[i].fv, m[i].pv, m[i].ovf};
      vectors++;
      if (out_f(i) != m[i].exp_f || out_p(i) != m[i].exp_p || out_bits(i) != want_bits) begin
        miscompares++;
        $display("FAIL model dut%0d cyc %0d: freq %0d want %0d, period %0d want %0d, fv/pv/ovf %b want %b",
                 i, cyc, out_f(i), m[i].exp_f, out_p(i), m[i].exp_p,
                 out_bits(i) & 3'b111, want_bits & 3'b111);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    bit r;
    @(posedge clk_intput);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      r = h2 & ~h3;
      for (int i = 0; i < 3; i++) model_step(i, enable, r, cyc);
      h3 = h2; h2 = h1; h1 = sig_in;
    end
    #1;
    check_all();
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic wave(input int half, input int n);
    repeat (n) begin
      sig_cnt++;
      if (sig_cnt >= half) begin
        sig_in  = ~sig_in;
        sig_cnt = 0;
      end
      step();
    end
  endtask

  vec_t tbl[4];

  initial begin
    int nfv, seen, per, found, left, half, off;

    tbl[0] = '{1'b1, 5, 300, 0, 10, 10};
    tbl[1] = '{1'b1, 25, 2300, 1, 20, 50};
    tbl[2] = '{1'b1, 10, 400, 0, 5, 20};
    tbl[3] = '{1'b1, 2, 300, 0, 25, 4};

    rst_n = 1'b0; enable = 1'b0; sig_in = 1'b0;
    model_reset();
    #12;
    check_all();
    chk("reset_freq_a", int'(fo_a), 0);
    chk("reset_ovf_c", int'(ov_c), 0);
    rst_n = 1'b1;
    hold(3);

    // Steady square waves; the last closed window of each phase is checked by hand value.
    for (int t = 0; t < 4; t++) begin
      enable = tbl[t].en;
      wave(tbl[t].half, tbl[t].cycles);
      chk($sformatf("tbl%0d_freq", t), out_f(tbl[t].dut), tbl[t].exp_f);
      chk($sformatf("tbl%0d_period", t), out_p(tbl[t].dut), tbl[t].exp_p);
    end

    // Rise landing exactly on the gate terminal cycle of dut_a.
    enable = 1'b0; sig_in = 1'b0;
    hold(5);
    enable = 1'b1;
    hold(1);
    hold(48); sig_in = 1'b1;
    hold(12); sig_in = 1'b0;
    hold(37); sig_in = 1'b1;
    hold(3);
    chk("term_fv", int'(fv_a), 1);
    chk("term_pv", int'(pv_a), 1);
    chk("term_freq", int'(fo_a), 2);
    chk("term_period", int'(po_a), 49);
    hold(100);
    chk("next_win_fv", int'(fv_a), 1);
    chk("next_win_freq", int'(fo_a), 0);

    // Disable for 3 cycles mid-window, then re-enable.
    sig_cnt = 0;
    wave(5, 250);
    chk("pre_dis_freq", int'(fo_a), 10);
    enable = 1'b0;
    for (int s = 0; s < 3; s++) begin
      wave(5, 1);
      chk("dis_hold_freq", int'(fo_a), 10);
      chk("dis_fv", int'(fv_a), 0);
    end
    enable = 1'b1;
    nfv = 0; seen = 0; per = -1;
    for (int s = 0; s < 100; s++) begin
      wave(5, 1);
      if (fv_a) nfv++;
      if (pv_a && seen == 0) begin
        seen = 1;
        per  = int'(po_a);
      end
    end
    chk("reen_no_fv", nfv, 0);
    chk("reen_pv_seen", seen, 1);
    chk("reen_period", per, 10);

    // Period timeout on the 4-bit instance.
    enable = 1'b0; sig_in = 1'b0;
    hold(5);
    enable = 1'b1;
    hold(1);
    sig_in = 1'b1; hold(3);
    sig_in = 1'b0; hold(40);
    sig_in = 1'b1;
    found = 0;
    for (int s = 0; s < 8; s++) begin
      step();
      if (pv_c && found == 0) begin
        found = 1;
        chk("ovf_period_c", int'(po_c), 15);
        chk("ovf_flag_c", int'(ov_c), 1);
      end
    end
    chk("ovf_pv_seen", found, 1);
    hold(20);
    chk("ovf_sticky_run", int'(ov_c), 1);
    enable = 1'b0;
    hold(3);
    chk("ovf_sticky_idle", int'(ov_c), 1);
    enable = 1'b1;
    hold(1);
    chk("ovf_clear_on_enable", int'(ov_c), 0);

    // Randomized frequencies and enable drops.
    left = 0; half = 5; off = 0;
    sig_cnt = 0;
    repeat (3000) begin
      if (left == 0) begin
        half = int'($urandom_range(2, 30));
        left = int'($urandom_range(50, 400));
      end
      left--;
      if (off > 0) begin
        off--;
        if (off == 0) enable = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        enable = 1'b0;
        off    = int'($urandom_range(1, 6));
      end
      wave(half, 1);
    end

    // Asynchronous reset mid-run.
    enable = 1'b1;
    wave(5, 150);
    sig_in = 1'b0;
    rst_n  = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_mid_period_a", int'(po_a), 0);
    hold(3);
    #1;
    rst_n = 1'b1;
    nfv = 0;
    for (int s = 1; s <= 101; s++) begin
      step();
      if (s <= 100 && (fv_a || pv_a)) nfv++;
      if (s == 101) chk("rst_first_fv", int'(fv_a), 1);
    end
    chk("rst_no_early_valid", nfv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
